prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 clk  input  1  single system clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 in_data  input  8  program byte stream from host.
REQ-004 in_valid  input  1  in_data holds a valid byte.
REQ-005 in_ready  output  1  loader can accept a byte; transfer occurs on a rising edge with in_valid&&in_ready.
REQ-006 restart  input  1  level, sampled each cycle; aborts the current load or run and reloads.
REQ-007 rom_mem0..rom_mem19  output  16 each  instruction words driven to the CPU program inputs.
REQ-008 cpu_reset  output  1  active-high hold for the CPU; 1 while loading.
REQ-009 loaded  output  1  program image complete; CPU released.
REQ-010 error  output  1  malformed image detected; sticky until restart or reset.

Function
REQ-011 States: IDLE, HDR, LOAD_HI, LOAD_LO, CHK (macro only), RUN, ERR.
REQ-012 Transitions:
- IDLE -> HDR unconditionally on the next edge.
- HDR accepts a count byte N:
  - 1..20: latch N, clear word index to 0, zero all rom_mem, go to LOAD_HI.
  - otherwise: go to ERR.
REQ-013 LOAD_HI accepted byte -> rom_mem[index][15:8]; LOAD_LO accepted byte -> rom_mem[index][7:0]. Words are big-endian.
REQ-014 After the LOAD_LO accept:
- index==N-1: go to RUN (or CHK when the macro is defined).
- otherwise: index+1, return to LOAD_HI.
REQ-015 in_ready=1 only in HDR, LOAD_HI, LOAD_LO and CHK, and only while restart=0. It is registered from state, so it is valid in the first cycle of each of those states.
REQ-016 A state ignores a byte while in_valid=0; there is no timeout.
REQ-017 Registered outputs:
- cpu_reset=0 and loaded=1 exactly in RUN.
- cpu_reset=1 in all other states.
- error=1 exactly in ERR.
REQ-018 rom_mem[N..19] hold 0 after a successful load; rom_mem hold their values through RUN and ERR until the next HDR accept.
REQ-019 restart=1 in any state -> IDLE on the next edge.
- restart wins over a simultaneous byte transfer, and that byte is dropped.
- cpu_reset reasserts in the cycle after restart is sampled.
REQ-020 RUN and ERR are absorbing: in_ready=0, and further bytes are not accepted.
REQ-021 Latency: cpu_reset falls at the first edge after the final byte accept. A full 20-word load takes 41 accepted bytes; a back-to-back stream is accepted at 1 byte per cycle.

Reset
REQ-022 Asserted reset (low) immediately forces:
- state=IDLE, index=0, N=0, all rom_mem=16'h0000;
- cpu_reset=1, loaded=0, error=0, in_ready=0.
REQ-023 Reset deasserted mid-stream: loading restarts from HDR; bytes of the interrupted image must be re-sent from the count byte.

Configuration
REQ-024 Macro LOADER_CHECKSUM_EN defined:
- after the last word, CHK accepts one byte;
- if it equals the XOR of all N*2 data bytes, go to RUN, else go to ERR;
- the count byte is excluded from the XOR;
- the running XOR clears at the HDR accept.
REQ-025 Macro undefined: no CHK state, no checksum logic; LOAD_LO of the last word goes directly to RUN.

Structure
REQ-026 Shared package cpu_loader_pkg holds ROM_DEPTH=20, WORD_W=16, BYTE_W=8, and the loader state enum.
REQ-027 No sub-module; the single flat module keeps the rom_mem array internally as ROM_DEPTH x WORD_W registers fanned out to the 20 ports.

Verification
REQ-028 Load of 3 words:
- stimulus: bytes 03,12,34,AB,CD,00,01 back-to-back;
- response: rom_mem0=1234, rom_mem1=ABCD, rom_mem2=0001, rom_mem3..19=0000;
- cpu_reset falls and loaded=1 one cycle after the last accept.
REQ-029 Count byte 00, then separately 15 (21): error=1, cpu_reset=1, in_ready=0; restart pulse returns to HDR with error=0.
REQ-030 Full 20-word load with in_valid toggling every other cycle: all 20 words correct, no byte lost or duplicated.
REQ-031 restart asserted in the same cycle as the 2nd data byte with in_valid=1: byte not accepted; after restart, a fresh image 01,BE,EF gives rom_mem0=BEEF.
REQ-032 reset pulsed low during LOAD_LO of word 5: all outputs at reset values immediately; a subsequent full image loads correctly.
REQ-033 LOADER_CHECKSUM_EN builds:
- image 02,11,22,33,44 with checksum 44 (XOR of 11,22,33,44): RUN;
- same image with checksum 45: ERR, error=1.

Source files
------------

// File: rtl/cpu_loader_pkg.sv
// Shared constants and state encoding for the CPU program loader.
// ROM geometry (20 x 16-bit words) and the byte width of the host stream.
// LOADER_CHECKSUM_EN adds the CHK state that checks the trailing XOR byte.
package cpu_loader_pkg;

   localparam int ROM_DEPTH = 20;
   localparam int WORD_W    = 16;
   localparam int BYTE_W    = 8;
   localparam int IDX_W     = $clog2(ROM_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HDR     = 3'd1,
      S_LOAD_HI = 3'd2,
      S_LOAD_LO = 3'd3,
`ifdef LOADER_CHECKSUM_EN
      S_CHK     = 3'd4,
`endif
      S_RUN     = 3'd5,
      S_ERR     = 3'd6
   } loader_state_e;

   // States in which the loader offers in_ready to the host.
   function automatic logic accepts_bytes(input loader_state_e s);
      logic r;
      r = (s == S_HDR) || (s == S_LOAD_HI) || (s == S_LOAD_LO);
`ifdef LOADER_CHECKSUM_EN
      r = r || (s == S_CHK);
`endif
      return r;
   endfunction

endpackage

// File: rtl/prog_loader.sv
// Program loader: count byte N then N big-endian 16-bit words into a 20-word ROM image; CPU held in reset meanwhile.
// Latency: one byte per cycle; cpu_reset drops on the edge that accepts the final byte of the image.
// Backpressure: in_ready is registered from the next state and forced low by restart; RUN and ERR accept nothing.
// Build option LOADER_CHECKSUM_EN: the image ends with an XOR checksum byte checked in the CHK state.
module prog_loader
   import cpu_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              restart,
   output logic [WORD_W-1:0] rom_mem0,
   output logic [WORD_W-1:0] rom_mem1,
   output logic [WORD_W-1:0] rom_mem2,
   output logic [WORD_W-1:0] rom_mem3,
   output logic [WORD_W-1:0] rom_mem4,
   output logic [WORD_W-1:0] rom_mem5,
   output logic [WORD_W-1:0] rom_mem6,
   output logic [WORD_W-1:0] rom_mem7,
   output logic [WORD_W-1:0] rom_mem8,
   output logic [WORD_W-1:0] rom_mem9,
   output logic [WORD_W-1:0] rom_mem10,
   output logic [WORD_W-1:0] rom_mem11,
   output logic [WORD_W-1:0] rom_mem12,
   output logic [WORD_W-1:0] rom_mem13,
   output logic [WORD_W-1:0] rom_mem14,
   output logic [WORD_W-1:0] rom_mem15,
   output logic [WORD_W-1:0] rom_mem16,
   output logic [WORD_W-1:0] rom_mem17,
   output logic [WORD_W-1:0] rom_mem18,
   output logic [WORD_W-1:0] rom_mem19,
   output logic              cpu_reset,
   output logic              loaded,
   output logic              error
);

   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

   loader_state_e     state;
   loader_state_e     state_nxt;
   logic              in_ready_q;
   logic              xfer;
   logic              cnt_ok;
   logic              last_word;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  cnt;
   logic [WORD_W-1:0] rom_mem [ROM_DEPTH];

   // restart gates in_ready directly so a byte offered alongside restart is never taken.
   assign in_ready  = in_ready_q & ~restart;
   assign xfer      = in_valid & in_ready;
   assign cnt_ok    = (in_data != '0) && (in_data <= BYTE_W'(ROM_DEPTH));
   assign last_word = (idx == (cnt - IDX_ONE));

`ifdef LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0] csum;

   // Running XOR of data bytes; cleared by each accepted count byte.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         csum <= '0;
      end else if (xfer) begin
         if (state == S_HDR) begin
            csum <= '0;
         end else if ((state == S_LOAD_HI) || (state == S_LOAD_LO)) begin
            csum <= csum ^ in_data;
         end
      end
   end
`endif

   // Next-state logic; restart overrides everything, including a byte in flight.
   always_comb begin
      state_nxt = state;
      if (restart) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:    state_nxt = S_HDR;
            S_HDR:     if (xfer) state_nxt = cnt_ok ? S_LOAD_HI : S_ERR;
            S_LOAD_HI: if (xfer) state_nxt = S_LOAD_LO;
`ifdef LOADER_CHECKSUM_EN
            S_LOAD_LO: if (xfer) state_nxt = last_word ? S_CHK : S_LOAD_HI;
            S_CHK:     if (xfer) state_nxt = (in_data == csum) ? S_RUN : S_ERR;
`else
            S_LOAD_LO: if (xfer) state_nxt = last_word ? S_RUN : S_LOAD_HI;
`endif
            default:   state_nxt = state;
         endcase
      end
   end

   // State register and outputs registered from the next state so they are valid on state entry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         in_ready_q <= 1'b0;
         cpu_reset  <= 1'b1;
         loaded     <= 1'b0;
         error      <= 1'b0;
      end else begin
         state      <= state_nxt;
         in_ready_q <= accepts_bytes(state_nxt);
         cpu_reset  <= (state_nxt != S_RUN);
         loaded     <= (state_nxt == S_RUN);
         error      <= (state_nxt == S_ERR);
      end
   end

   // ROM image, word index and word count; the image is only cleared by a valid count byte.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ROM_DEPTH; i++) rom_mem[i] <= '0;
         idx <= '0;
         cnt <= '0;
      end else if (xfer) begin
         case (state)
            S_HDR: begin
               if (cnt_ok) begin
                  for (int i = 0; i < ROM_DEPTH; i++) rom_mem[i] <= '0;
                  idx <= '0;
                  cnt <= in_data[IDX_W-1:0];
               end
            end
            S_LOAD_HI: rom_mem[idx][WORD_W-1:BYTE_W] <= in_data;
            S_LOAD_LO: begin
               rom_mem[idx][BYTE_W-1:0] <= in_data;
               if (!last_word) idx <= idx + IDX_ONE;
            end
            default: ;
         endcase
      end
   end

   assign rom_mem0  = rom_mem[0];
   assign rom_mem1  = rom_mem[1];
   assign rom_mem2  = rom_mem[2];
   assign rom_mem3  = rom_mem[3];
   assign rom_mem4  = rom_mem[4];
   assign rom_mem5  = rom_mem[5];
   assign rom_mem6  = rom_mem[6];
   assign rom_mem7  = rom_mem[7];
   assign rom_mem8  = rom_mem[8];
   assign rom_mem9  = rom_mem[9];
   assign rom_mem10 = rom_mem[10];
   assign rom_mem11 = rom_mem[11];
   assign rom_mem12 = rom_mem[12];
   assign rom_mem13 = rom_mem[13];
   assign rom_mem14 = rom_mem[14];
   assign rom_mem15 = rom_mem[15];
   assign rom_mem16 = rom_mem[16];
   assign rom_mem17 = rom_mem[17];
   assign rom_mem18 = rom_mem[18];
   assign rom_mem19 = rom_mem[19];

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: reset values, loads, bad counts, restart, mid-load reset.
// Inputs are driven and outputs sampled on the falling clock edge.
// With LOADER_CHECKSUM_EN defined every image is closed with its XOR checksum byte.
module tb_prog_loader;

   logic        clk      = 1'b0;
   logic        reset    = 1'b1;
   logic [7:0]  in_data  = 8'h00;
   logic        in_valid = 1'b0;
   logic        restart  = 1'b0;
   logic        in_ready;
   logic        cpu_reset;
   logic        loaded;
   logic        error;
   logic [15:0] rm [20];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc   = 0;

`ifdef LOADER_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   prog_loader dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .restart(restart),
      .rom_mem0(rm[0]),   .rom_mem1(rm[1]),   .rom_mem2(rm[2]),   .rom_mem3(rm[3]),
      .rom_mem4(rm[4]),   .rom_mem5(rm[5]),   .rom_mem6(rm[6]),   .rom_mem7(rm[7]),
      .rom_mem8(rm[8]),   .rom_mem9(rm[9]),   .rom_mem10(rm[10]), .rom_mem11(rm[11]),
      .rom_mem12(rm[12]), .rom_mem13(rm[13]), .rom_mem14(rm[14]), .rom_mem15(rm[15]),
      .rom_mem16(rm[16]), .rom_mem17(rm[17]), .rom_mem18(rm[18]), .rom_mem19(rm[19]),
      .cpu_reset(cpu_reset), .loaded(loaded), .error(error)
   );

   always #5 clk = ~clk;

   // Cycle counter and handshake counter.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset && in_valid && in_ready) acc <= acc + 1;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Offer one byte from a falling edge; returns on the falling edge after it was taken.
   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", 32'(n < 64), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic end_image(input logic [7:0] x);
`ifdef LOADER_CHECKSUM_EN
      send(x);
`else
      in_data = x;
`endif
   endtask

   // Restart pulse; returns in HDR with in_ready expected high.
   task automatic restart_pulse;
      @(negedge clk);
      in_valid = 1'b0;
      restart  = 1'b1;
      @(negedge clk);
      restart  = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int          c0;
      int          a0;
      logic [7:0]  xs;
      logic [7:0]  hi;
      logic [7:0]  lo;

      // Reset values
      #2 reset = 1'b0;
      #1;
      chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("rst_loaded",    32'(loaded),    32'd0);
      chk("rst_error",     32'(error),     32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_rom0",      32'(rm[0]),     32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("hdr_in_ready",  32'(in_ready),  32'd1);
      chk("hdr_cpu_reset", 32'(cpu_reset), 32'd1);

      // Three-word image, back to back
      c0 = cyc;
      send(8'h03); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD); send(8'h00);
      chk("pre_last_cpu_reset", 32'(cpu_reset), 32'd1);
      send(8'h01);
      end_image(8'h41);
      chk("load3_cycles",   32'(cyc - c0),   32'(7 + CK));
      chk("load3_cpu_reset", 32'(cpu_reset), 32'd0);
      chk("load3_loaded",   32'(loaded),     32'd1);
      chk("load3_in_ready", 32'(in_ready),   32'd0);
      chk("load3_error",    32'(error),      32'd0);
      chk("load3_rom0",     32'(rm[0]),      32'h1234);
      chk("load3_rom1",     32'(rm[1]),      32'hABCD);
      chk("load3_rom2",     32'(rm[2]),      32'h0001);
      for (int i = 3; i < 20; i++) chk($sformatf("load3_rom%0d", i), 32'(rm[i]), 32'h0);

      // RUN ignores further bytes
      a0 = acc;
      in_data  = 8'h55;
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      chk("run_no_accept", 32'(acc - a0), 32'd0);
      chk("run_hold_rom0", 32'(rm[0]),    32'h1234);
      chk("run_loaded",    32'(loaded),   32'd1);

      // Restart from RUN
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      chk("restart_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("restart_loaded",    32'(loaded),    32'd0);
      @(negedge clk);
      chk("restart_hdr_ready", 32'(in_ready),  32'd1);
      chk("restart_rom_hold",  32'(rm[0]),     32'h1234);

      // Bad counts 00 and 21
      send(8'h00);
      chk("cnt0_error",     32'(error),     32'd1);
      chk("cnt0_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("cnt0_in_ready",  32'(in_ready),  32'd0);
      chk("cnt0_loaded",    32'(loaded),    32'd0);
      restart_pulse;
      chk("cnt0_clr_error", 32'(error),     32'd0);
      chk("cnt0_clr_ready", 32'(in_ready),  32'd1);
      send(8'h15);
      chk("cnt21_error",    32'(error),     32'd1);
      chk("cnt21_in_ready", 32'(in_ready),  32'd0);
      chk("cnt21_cpu_reset", 32'(cpu_reset), 32'd1);
      restart_pulse;
      chk("cnt21_clr_error", 32'(error),    32'd0);
      chk("cnt21_clr_ready", 32'(in_ready), 32'd1);

      // Full 20-word image with in_valid toggling every other cycle
      a0 = acc;
      xs = 8'h00;
      send(8'h14);
      @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         hi = 8'(i);
         lo = 8'hA0 + 8'(i);
         xs = xs ^ hi ^ lo;
         send(hi);
         @(negedge clk);
         send(lo);
         @(negedge clk);
      end
      end_image(xs);
      chk("full_accepts",   32'(acc - a0),   32'(41 + CK));
      chk("full_loaded",    32'(loaded),     32'd1);
      chk("full_cpu_reset", 32'(cpu_reset),  32'd0);
      for (int i = 0; i < 20; i++)
         chk($sformatf("full_rom%0d", i), 32'(rm[i]), {16'h0, 8'(i), 8'hA0 + 8'(i)});

      // Restart coinciding with the second data byte
      restart_pulse;
      a0 = acc;
      send(8'h02);
      send(8'h11);
      in_data  = 8'h22;
      in_valid = 1'b1;
      restart  = 1'b1;
      #1;
      chk("restart_blocks_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      restart  = 1'b0;
      in_valid = 1'b0;
      chk("restart_drop",     32'(acc - a0),   32'd2);
      chk("restart_hold_cpu", 32'(cpu_reset),  32'd1);
      @(negedge clk);
      chk("restart2_ready",   32'(in_ready),   32'd1);
      send(8'h01); send(8'hBE); send(8'hEF);
      end_image(8'h51);
      chk("beef_rom0",   32'(rm[0]),  32'hBEEF);
      chk("beef_rom1",   32'(rm[1]),  32'h0);
      chk("beef_rom19",  32'(rm[19]), 32'h0);
      chk("beef_loaded", 32'(loaded), 32'd1);

      // Reset during LOAD_LO of word 5
      restart_pulse;
      send(8'h14);
      for (int i = 0; i < 5; i++) begin
         send(8'h30 + 8'(i));
         send(8'h40 + 8'(i));
      end
      send(8'h35);
      reset = 1'b0;
      #1;
      chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("midrst_loaded",    32'(loaded),    32'd0);
      chk("midrst_error",     32'(error),     32'd0);
      chk("midrst_in_ready",  32'(in_ready),  32'd0);
      chk("midrst_rom0",      32'(rm[0]),     32'h0);
      chk("midrst_rom4",      32'(rm[4]),     32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_hdr_ready", 32'(in_ready),  32'd1);

      // Full 20-word image back to back after reset
      c0 = cyc;
      a0 = acc;
      xs = 8'h00;
      send(8'h14);
      for (int i = 0; i < 20; i++) begin
         hi = 8'hF0 ^ 8'(i);
         lo = 8'(i * 3);
         xs = xs ^ hi ^ lo;
         send(hi);
         send(lo);
      end
      end_image(xs);
      chk("b2b_cycles",    32'(cyc - c0),  32'(41 + CK));
      chk("b2b_accepts",   32'(acc - a0),  32'(41 + CK));
      chk("b2b_loaded",    32'(loaded),    32'd1);
      for (int i = 0; i < 20; i++)
         chk($sformatf("b2b_rom%0d", i), 32'(rm[i]), {16'h0, 8'hF0 ^ 8'(i), 8'(i * 3)});

`ifdef LOADER_CHECKSUM_EN
      // Checksum accepted and rejected
      restart_pulse;
      send(8'h02); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      chk("chk_in_ready",  32'(in_ready),  32'd1);
      chk("chk_cpu_reset", 32'(cpu_reset), 32'd1);
      send(8'h44);
      chk("chk_good_loaded", 32'(loaded), 32'd1);
      chk("chk_good_error",  32'(error),  32'd0);
      restart_pulse;
      send(8'h02); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      send(8'h45);
      chk("chk_bad_error",     32'(error),     32'd1);
      chk("chk_bad_loaded",    32'(loaded),    32'd0);
      chk("chk_bad_cpu_reset", 32'(cpu_reset), 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
